// File: rtl/apple_riscv_pkg.sv
// ---------------------------------------------------------------------------
// | apple_riscv_pkg                                                         |
// | Shared constants for the apple_riscv SoC: word width, memory map,       |
// | byte-lane encodings, RV32I opcodes and the core sequencer states.       |
// | Rev 1.0                                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

package apple_riscv_pkg;

  localparam int XLEN = 32;

  // Memory map: both RAMs start at address 0 in their own (Harvard) spaces
  localparam logic [XLEN-1:0] INSTR_BASE   = 32'h0000_0000;
  localparam logic [XLEN-1:0] DATA_BASE    = 32'h0000_0000;
  localparam int              INSTR_RAM_AW = 20;
  localparam int              DATA_RAM_AW  = 20;

  // Byte-lane enables (lane 0 = least significant byte)
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Core sequencer: fetch, execute, and a second cycle for load data
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  // Lanes touched by a store of size funct3[1:0] at byte offset off
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return BE_BYTE << off;
      2'b01:   return off[1] ? (BE_HALF << 2) : BE_HALF;
      default: return BE_WORD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/apple_riscv.sv
// ---------------------------------------------------------------------------
// | apple_riscv                                                             |
// | Compact multi-cycle RV32I core: FETCH -> EXEC (-> LOAD) per             |
// | instruction. Uses synchronous-read instruction and data memories.       |
// | Rev 1.0                                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

module apple_riscv
  import apple_riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] o_instr_addr,
  output logic            o_instr_rd,
  input  logic [XLEN-1:0] i_instr_dout,
  output logic [XLEN-1:0] o_data_addr,
  output logic            o_data_rd,
  output logic            o_data_wr,
  output logic [3:0]      o_data_be,
  output logic [XLEN-1:0] o_data_wdata,
  input  logic [XLEN-1:0] i_data_rdata
);

  state_t          r_state, w_next_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_regs [0:31];

  // The instruction RAM holds its output after FETCH, so it stays valid
  // through EXEC and LOAD without a local instruction register.
  logic [XLEN-1:0] w_instr;
  logic [6:0]      w_opcode;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [XLEN-1:0] w_rs1v, w_rs2v, w_alu_b, w_alu, w_addr, w_pc4;
  logic [XLEN-1:0] w_next_pc, w_wb_data, w_ld_shift, w_ld_val, w_rf_wd;
  logic            w_taken, w_wb_en, w_rf_we;

  assign w_instr  = i_instr_dout;
  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_f3     = w_instr[14:12];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];
  assign w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s  = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b  = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_u  = {w_instr[31:12], 12'd0};
  assign w_imm_j  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
  assign w_rs1v   = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2v   = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
  assign w_alu_b  = (w_opcode == OPC_OP) ? w_rs2v : w_imm_i;
  assign w_addr   = w_rs1v + ((w_opcode == OPC_STORE) ? w_imm_s : w_imm_i);
  assign w_pc4    = r_pc + 32'd4;

  // ALU for OP / OP-IMM; bit 30 selects SUB (register form only) and SRA
  always_comb begin
    w_alu = '0;
    case (w_f3)
      3'b000: w_alu = ((w_opcode == OPC_OP) && w_instr[30]) ? w_rs1v - w_alu_b : w_rs1v + w_alu_b;
      3'b001: w_alu = w_rs1v << w_alu_b[4:0];
      3'b010: w_alu = {31'd0, $signed(w_rs1v) < $signed(w_alu_b)};
      3'b011: w_alu = {31'd0, w_rs1v < w_alu_b};
      3'b100: w_alu = w_rs1v ^ w_alu_b;
      3'b101: w_alu = w_instr[30] ? $signed(w_rs1v) >>> w_alu_b[4:0] : w_rs1v >> w_alu_b[4:0];
      3'b110: w_alu = w_rs1v | w_alu_b;
      3'b111: w_alu = w_rs1v & w_alu_b;
      default: w_alu = '0;
    endcase
  end

  // Branch condition
  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000:  w_taken = (w_rs1v == w_rs2v);
      3'b001:  w_taken = (w_rs1v != w_rs2v);
      3'b100:  w_taken = ($signed(w_rs1v) <  $signed(w_rs2v));
      3'b101:  w_taken = ($signed(w_rs1v) >= $signed(w_rs2v));
      3'b110:  w_taken = (w_rs1v <  w_rs2v);
      3'b111:  w_taken = (w_rs1v >= w_rs2v);
      default: w_taken = 1'b0;
    endcase
  end

  // Next PC and write-back selection for single-cycle-execute instructions
  always_comb begin
    w_next_pc = w_pc4;
    w_wb_en   = 1'b0;
    w_wb_data = w_alu;
    case (w_opcode)
      OPC_LUI:    begin w_wb_en = 1'b1; w_wb_data = w_imm_u; end
      OPC_AUIPC:  begin w_wb_en = 1'b1; w_wb_data = r_pc + w_imm_u; end
      OPC_JAL:    begin w_wb_en = 1'b1; w_wb_data = w_pc4; w_next_pc = r_pc + w_imm_j; end
      OPC_JALR:   begin w_wb_en = 1'b1; w_wb_data = w_pc4; w_next_pc = (w_rs1v + w_imm_i) & ~32'd1; end
      OPC_BRANCH: if (w_taken) w_next_pc = r_pc + w_imm_b;
      OPC_OPIMM,
      OPC_OP:     w_wb_en = 1'b1;
      default:    ;
    endcase
  end

  // Load alignment and sign/zero extension of the returned word
  always_comb begin
    w_ld_shift = i_data_rdata >> {w_addr[1:0], 3'b000};
    case (w_f3)
      3'b000:  w_ld_val = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
      3'b001:  w_ld_val = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
      3'b100:  w_ld_val = {24'd0, w_ld_shift[7:0]};
      3'b101:  w_ld_val = {16'd0, w_ld_shift[15:0]};
      default: w_ld_val = w_ld_shift;
    endcase
  end

  assign w_rf_we = (((r_state == S_EXEC) && w_wb_en) || (r_state == S_LOAD)) && (w_rd != 5'd0);
  assign w_rf_wd = (r_state == S_LOAD) ? w_ld_val : w_wb_data;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: w_next_state = S_EXEC;
      S_EXEC:  w_next_state = (w_opcode == OPC_LOAD) ? S_LOAD : S_FETCH;
      S_LOAD:  w_next_state = S_FETCH;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Memory-interface outputs
  always_comb begin
    o_instr_addr = r_pc;
    o_instr_rd   = (r_state == S_FETCH);
    o_data_addr  = w_addr;
    o_data_rd    = (r_state == S_EXEC) && (w_opcode == OPC_LOAD);
    o_data_wr    = (r_state == S_EXEC) && (w_opcode == OPC_STORE);
    o_data_be    = store_be(w_f3[1:0], w_addr[1:0]);
    case (w_f3[1:0])
      2'b00:   o_data_wdata = {4{w_rs2v[7:0]}};
      2'b01:   o_data_wdata = {2{w_rs2v[15:0]}};
      default: o_data_wdata = w_rs2v;
    endcase
  end

  // Program counter: advances at the end of EXEC, or after load data returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                             r_pc <= '0;
    else if ((r_state == S_EXEC) && (w_opcode != OPC_LOAD)) r_pc <= w_next_pc;
    else if (r_state == S_LOAD)                             r_pc <= w_pc4;
  end

  // Register file write port; x0 is never written
  always_ff @(posedge clk) begin
    if (w_rf_we) r_regs[w_rd] <= w_rf_wd;
  end

endmodule

`default_nettype wire

// File: rtl/data_ram_4lane.sv
// ---------------------------------------------------------------------------
// | data_ram_4lane                                                          |
// | Word RAM built from four byte lanes with per-lane write enables and a   |
// | registered read that returns old data on a same-word read/write.        |
// | Rev 1.0                                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

module data_ram_4lane #(
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-3:0] i_addr,
  input  logic                  i_rd,
  input  logic                  i_wr,
  input  logic [3:0]            i_be,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  // ram_symbolN holds byte N of each little-endian word
  reg   [7:0]  ram_symbol0 [0:DEPTH-1];
  reg   [7:0]  ram_symbol1 [0:DEPTH-1];
  reg   [7:0]  ram_symbol2 [0:DEPTH-1];
  reg   [7:0]  ram_symbol3 [0:DEPTH-1];
  logic [31:0] r_rdata;

  // Per-lane writes; storage is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (i_wr && i_be[0]) ram_symbol0[i_addr] <= i_wdata[7:0];
    if (i_wr && i_be[1]) ram_symbol1[i_addr] <= i_wdata[15:8];
    if (i_wr && i_be[2]) ram_symbol2[i_addr] <= i_wdata[23:16];
    if (i_wr && i_be[3]) ram_symbol3[i_addr] <= i_wdata[31:24];
  end

  // Registered read samples pre-write contents (read-old-data)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_rd) r_rdata <= {ram_symbol3[i_addr], ram_symbol2[i_addr],
                               ram_symbol1[i_addr], ram_symbol0[i_addr]};
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/instr_ram_1r.sv
// ---------------------------------------------------------------------------
// | instr_ram_1r                                                            |
// | Single-port word RAM with registered read (1-cycle latency). Storage    |
// | is never reset so a preloaded image survives reset.                     |
// | Rev 1.0                                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

module instr_ram_1r #(
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-3:0] i_addr,
  input  logic                  i_rd,
  input  logic                  i_we,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_dout
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  reg   [31:0] ram [0:DEPTH-1];
  logic [31:0] r_dout;

  // Optional write side (in-system load); storage itself has no reset
  always_ff @(posedge clk) begin
    if (i_we) ram[i_addr] <= i_wdata;
  end

  // Registered read; output holds when no read is requested
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_dout <= '0;
    else if (i_rd) r_dout <= ram[i_addr];
  end

  assign o_dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/apple_riscv_soc.sv
// ---------------------------------------------------------------------------
// | apple_riscv_soc                                                         |
// | apple_riscv core with Harvard instruction RAM and byte-lane data RAM.   |
// | Data accesses above the RAM window are dropped / read as zero.          |
// | Rev 1.0                                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

module apple_riscv_soc
  import apple_riscv_pkg::*;
#(
  parameter int INSTR_RAM_ADDR_WIDTH = INSTR_RAM_AW,
  parameter int DATA_RAM_ADDR_WIDTH  = DATA_RAM_AW
) (
  input  logic clk,
  input  logic reset
);

  logic [XLEN-1:0] w_instr_addr, w_instr_dout, w_instr_off;
  logic            w_instr_rd;
  logic [XLEN-1:0] w_data_addr, w_data_wdata, w_data_rdata, w_ram_rdata, w_data_off;
  logic            w_data_rd, w_data_wr, w_data_in_range;
  logic [3:0]      w_data_byte_en;
  logic            r_rd_in_range;
  logic            w_unused;

  apple_riscv u_core (
    .clk          (clk),
    .rst_n        (reset),
    .o_instr_addr (w_instr_addr),
    .o_instr_rd   (w_instr_rd),
    .i_instr_dout (w_instr_dout),
    .o_data_addr  (w_data_addr),
    .o_data_rd    (w_data_rd),
    .o_data_wr    (w_data_wr),
    .o_data_be    (w_data_byte_en),
    .o_data_wdata (w_data_wdata),
    .i_data_rdata (w_data_rdata)
  );

  // Fetch ignores the upper address bits, so fetches wrap modulo RAM size.
  // Data accesses must fall inside the RAM window to take effect.
  assign w_instr_off     = w_instr_addr - INSTR_BASE;
  assign w_data_off      = w_data_addr - DATA_BASE;
  assign w_data_in_range = ((w_data_off >> DATA_RAM_ADDR_WIDTH) == '0);
  assign w_unused        = ^{w_instr_off[XLEN-1:INSTR_RAM_ADDR_WIDTH], w_instr_off[1:0], w_data_off[1:0]};

  instr_ram_1r #(
    .ADDR_WIDTH (INSTR_RAM_ADDR_WIDTH)
  ) instruction_ram (
    .clk     (clk),
    .rst_n   (reset),
    .i_addr  (w_instr_off[INSTR_RAM_ADDR_WIDTH-1:2]),
    .i_rd    (w_instr_rd),
    .i_we    (1'b0),
    .i_wdata ('0),
    .o_dout  (w_instr_dout)
  );

  data_ram_4lane #(
    .ADDR_WIDTH (DATA_RAM_ADDR_WIDTH)
  ) data_ram (
    .clk     (clk),
    .rst_n   (reset),
    .i_addr  (w_data_off[DATA_RAM_ADDR_WIDTH-1:2]),
    .i_rd    (w_data_rd),
    .i_wr    (w_data_wr && w_data_in_range),
    .i_be    (w_data_byte_en),
    .i_wdata (w_data_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Remember whether the outstanding read was in range, aligned with RAM latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_rd_in_range <= 1'b0;
    else if (w_data_rd) r_rd_in_range <= w_data_in_range;
  end

  assign w_data_rdata = r_rd_in_range ? w_ram_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_apple_riscv_soc.sv
// ---------------------------------------------------------------------------
// | tb_apple_riscv_soc                                                      |
// | Self-checking bench: preloads programs/data hierarchically, runs to a   |
// | halt loop and compares RAM words against a scoreboard queue.           |
// | Rev 1.0                                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_apple_riscv_soc;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned word;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] prog[$];

  apple_riscv_soc dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  // RV32I encoders
  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] halt();
    return 32'h0000_006F;  // jal x0, 0
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(7'b0010011, rd, 3'b000, rs1, imm);
  endfunction

  function automatic logic [31:0] load(input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(7'b0000011, rd, f3, rs1, imm);
  endfunction

  function automatic logic [31:0] rd_word(input int unsigned w);
    return {dut.data_ram.ram_symbol3[w], dut.data_ram.ram_symbol2[w],
            dut.data_ram.ram_symbol1[w], dut.data_ram.ram_symbol0[w]};
  endfunction

  task automatic wr_word(input int unsigned w, input logic [31:0] v);
    dut.data_ram.ram_symbol0[w] = v[7:0];
    dut.data_ram.ram_symbol1[w] = v[15:8];
    dut.data_ram.ram_symbol2[w] = v[23:16];
    dut.data_ram.ram_symbol3[w] = v[31:24];
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      dut.instruction_ram.ram[i] = 32'h0;
      wr_word(i, 32'h0);
    end
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) dut.instruction_ram.ram[i] = prog[i];
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_to_halt(output bit ok);
    logic [31:0] halt_pc;
    halt_pc = 32'(prog.size() - 1) * 32'd4;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (dut.u_core.r_pc == halt_pc) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    prog = {addi(5'd1, 5'd0, 32'h55), halt()};
    hold_reset();
    clear_mem();
    load_prog();
    n_checks++;
    if (dut.u_core.r_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc: got %h expected %h", dut.u_core.r_pc, 32'h0);
    end
    n_checks++;
    if (dut.w_instr_dout !== 32'h0) begin
      n_fail++; $display("FAIL reset_instr_dout: got %h expected %h", dut.w_instr_dout, 32'h0);
    end
    n_checks++;
    if (dut.w_data_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_data_rdata: got %h expected %h", dut.w_data_rdata, 32'h0);
    end
    release_reset();
    #1;
    n_checks++;
    if (dut.w_instr_addr !== 32'h0 || dut.w_instr_rd !== 1'b1) begin
      n_fail++; $display("FAIL first_fetch: got addr %h rd %b expected addr 0 rd 1", dut.w_instr_addr, dut.w_instr_rd);
    end
    @(negedge clk);
    n_checks++;
    if (dut.w_instr_dout !== prog[0]) begin
      n_fail++; $display("FAIL first_instr: got %h expected %h", dut.w_instr_dout, prog[0]);
    end
  endtask

  task automatic test_store_word();
    bit   ok;
    exp_t e;
    hold_reset();
    clear_mem();
    prog = {enc_lui(5'd1, 20'h12345), addi(5'd1, 5'd1, 32'h678),
            enc_s(3'b010, 5'd0, 5'd1, 32'd16), halt()};
    sb_q.push_back('{4, 32'h1234_5678, "sw_word4"});
    load_prog();
    release_reset();
    run_to_halt(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sw_timeout: got no halt expected halt"); end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (rd_word(e.word) !== e.val) begin
        n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_word(e.word), e.val);
      end
    end
  endtask

  task automatic test_byte_store();
    bit   ok;
    exp_t e;
    hold_reset();
    clear_mem();
    wr_word(1, 32'h1122_3344);
    wr_word(2, 32'hFFFF_FFFF);
    wr_word(3, 32'hFFFF_FFFF);
    prog = {addi(5'd1, 5'd0, 32'hAB), enc_s(3'b000, 5'd0, 5'd1, 32'd5),
            addi(5'd1, 5'd0, 32'h123), enc_s(3'b001, 5'd0, 5'd1, 32'd10),
            enc_s(3'b001, 5'd0, 5'd1, 32'd12), halt()};
    sb_q.push_back('{1, 32'h1122_AB44, "sb_lane1"});
    sb_q.push_back('{2, 32'h0123_FFFF, "sh_upper"});
    sb_q.push_back('{3, 32'hFFFF_0123, "sh_lower"});
    load_prog();
    release_reset();
    run_to_halt(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sb_timeout: got no halt expected halt"); end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (rd_word(e.word) !== e.val) begin
        n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_word(e.word), e.val);
      end
    end
  endtask

  task automatic test_load();
    bit   ok;
    exp_t e;
    hold_reset();
    clear_mem();
    dut.data_ram.ram_symbol3[8] = 8'hDE;
    dut.data_ram.ram_symbol2[8] = 8'hAD;
    dut.data_ram.ram_symbol1[8] = 8'hBE;
    dut.data_ram.ram_symbol0[8] = 8'hEF;
    prog = {load(3'b010, 5'd2, 5'd0, 32'd32), enc_s(3'b010, 5'd0, 5'd2, 32'd36),
            load(3'b000, 5'd7, 5'd0, 32'd33), enc_s(3'b010, 5'd0, 5'd7, 32'd44),
            load(3'b100, 5'd8, 5'd0, 32'd35), enc_s(3'b010, 5'd0, 5'd8, 32'd52),
            load(3'b001, 5'd9, 5'd0, 32'd34), enc_s(3'b010, 5'd0, 5'd9, 32'd56),
            halt()};
    sb_q.push_back('{9,  32'hDEAD_BEEF, "lw_copy"});
    sb_q.push_back('{11, 32'hFFFF_FFBE, "lb_sext"});
    sb_q.push_back('{13, 32'h0000_00DE, "lbu_zext"});
    sb_q.push_back('{14, 32'hFFFF_DEAD, "lh_upper"});
    load_prog();
    release_reset();
    run_to_halt(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL load_timeout: got no halt expected halt"); end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (rd_word(e.word) !== e.val) begin
        n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_word(e.word), e.val);
      end
    end
  endtask

  task automatic test_out_of_range();
    bit   ok;
    exp_t e;
    hold_reset();
    clear_mem();
    wr_word(0, 32'h5A5A_5A5A);   // word an address wrap would alias onto
    wr_word(12, 32'hFFFF_FFFF);
    prog = {enc_lui(5'd5, 20'h00100), enc_lui(5'd1, 20'h12345),
            enc_s(3'b010, 5'd5, 5'd1, 32'd0), load(3'b010, 5'd6, 5'd5, 32'd0),
            enc_s(3'b010, 5'd0, 5'd6, 32'd48), halt()};
    sb_q.push_back('{0,  32'h5A5A_5A5A, "oor_write_dropped"});
    sb_q.push_back('{12, 32'h0000_0000, "oor_read_zero"});
    load_prog();
    release_reset();
    run_to_halt(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL oor_timeout: got no halt expected halt"); end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (rd_word(e.word) !== e.val) begin
        n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_word(e.word), e.val);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit   ok;
    exp_t e;
    hold_reset();
    clear_mem();
    wr_word(11, 32'hCAFE_F00D);
    prog = {addi(5'd3, 5'd0, 32'd0), addi(5'd4, 5'd0, 32'd50),
            addi(5'd3, 5'd3, 32'd1), enc_b(3'b001, 5'd3, 5'd4, 32'hFFFF_FFFC),
            enc_s(3'b010, 5'd0, 5'd3, 32'd40), halt()};
    load_prog();
    release_reset();
    repeat (60) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (dut.u_core.r_pc !== 32'h0) begin
      n_fail++; $display("FAIL midrun_pc_async: got %h expected %h", dut.u_core.r_pc, 32'h0);
    end
    n_checks++;
    if (dut.instruction_ram.ram[0] !== prog[0]) begin
      n_fail++; $display("FAIL midrun_iram_kept: got %h expected %h", dut.instruction_ram.ram[0], prog[0]);
    end
    n_checks++;
    if (rd_word(11) !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL midrun_dram_kept: got %h expected %h", rd_word(11), 32'hCAFE_F00D);
    end
    n_checks++;
    if (rd_word(10) !== 32'h0) begin
      n_fail++; $display("FAIL midrun_not_done: got %h expected %h", rd_word(10), 32'h0);
    end
    repeat (3) @(negedge clk);
    sb_q.push_back('{10, 32'd50, "midrun_rerun_result"});
    sb_q.push_back('{11, 32'hCAFE_F00D, "midrun_sentinel"});
    release_reset();
    run_to_halt(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midrun_timeout: got no halt expected halt"); end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (rd_word(e.word) !== e.val) begin
        n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_word(e.word), e.val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_byte_store();
    test_load();
    test_out_of_range();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
